// File: rtl/d8_imem_pkg.sv
// Shared d8 instruction-memory definitions: FSM state encoding and default geometry.
package d8_imem_pkg;

    localparam int unsigned D8_IMEM_ADDR_W_DEF   = 8;
    localparam int unsigned D8_IMEM_IW_BYTES_DEF = 4;
    localparam int unsigned D8_IMEM_BYTE_W       = 8;

    typedef enum logic {
        D8_IMEM_ST_CLEAR = 1'b0,
        D8_IMEM_ST_READY = 1'b1
    } d8_imem_st_e;

endpackage

// File: rtl/d8_imem_bank.sv
// Byte-wide RAM bank: one write port, one synchronous read port with optional write-first bypass.
module d8_imem_bank
    import d8_imem_pkg::*;
#(
    parameter int unsigned ADDR_W = D8_IMEM_ADDR_W_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      we,
    input  logic [ADDR_W-1:0]         wa,
    input  logic [D8_IMEM_BYTE_W-1:0] wd,
    input  logic                      re,
    input  logic [ADDR_W-1:0]         ra,
    input  logic                      byp,
    output logic [D8_IMEM_BYTE_W-1:0] rd
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [D8_IMEM_BYTE_W-1:0] mem [DEPTH];
    logic [D8_IMEM_BYTE_W-1:0] rd_d;
    logic [D8_IMEM_BYTE_W-1:0] rd_q;

    // Storage carries no reset so it maps onto RAM primitives.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wa] <= wd;
        end
    end

    // Read register only loads on a read, so the lane holds between fetches.
    always_comb begin
        rd_d = rd_q;
        if (re) begin
            rd_d = byp ? wd : mem[ra];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q <= '0;
        end else begin
            rd_q <= rd_d;
        end
    end

    assign rd = rd_q;

endmodule

// File: rtl/d8_imem.sv
// d8 instruction memory: multi-byte wrapping fetch, byte write port, and hardware clear sequencer.
module d8_imem
    import d8_imem_pkg::*;
#(
    parameter int unsigned ADDR_W         = D8_IMEM_ADDR_W_DEF,
    parameter int unsigned IW_BYTES       = D8_IMEM_IW_BYTES_DEF,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic                         sys_clk,
    input  logic                         sys_rst_n,
    input  logic                         clr_start,
    output logic                         busy,
    input  logic                         fetch_req,
    input  logic [ADDR_W-1:0]            fetch_adr,
    output logic                         fetch_rdy,
    output logic                         fetch_vld,
    output logic [8*IW_BYTES-1:0]        fetch_dout,
    input  logic                         wr_en,
    input  logic [ADDR_W-1:0]            wr_adr,
    input  logic [D8_IMEM_BYTE_W-1:0]    wr_dat,
    output logic                         wr_rdy
);

    localparam logic [ADDR_W-1:0] CNT_LAST = {ADDR_W{1'b1}};

    d8_imem_st_e               state_d, state_q;
    logic [ADDR_W-1:0]         cnt_d, cnt_q;
    logic                      busy_d, busy_q;
    logic                      rdy_d, rdy_q;
    logic                      fetch_vld_d, fetch_vld_q;

    logic                      fetch_acc;
    logic                      wr_acc;
    logic                      bank_we;
    logic [ADDR_W-1:0]         bank_wa;
    logic [D8_IMEM_BYTE_W-1:0] bank_wd;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= CLEAR_ON_RESET ? D8_IMEM_ST_CLEAR : D8_IMEM_ST_READY;
            cnt_q       <= '0;
            busy_q      <= CLEAR_ON_RESET;
            rdy_q       <= !CLEAR_ON_RESET;
            fetch_vld_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            rdy_q       <= rdy_d;
            fetch_vld_q <= fetch_vld_d;
        end
    end

    // Next state, clear sweep and port acceptance.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        fetch_acc   = fetch_req && rdy_q;
        wr_acc      = wr_en && rdy_q;
        bank_we     = wr_acc;
        bank_wa     = wr_adr;
        bank_wd     = wr_dat;

        unique case (state_q)
            D8_IMEM_ST_CLEAR: begin
                bank_we = 1'b1;
                bank_wa = cnt_q;
                bank_wd = '0;
                cnt_d   = ADDR_W'(cnt_q + ADDR_W'(1));
                if (cnt_q == CNT_LAST) begin
                    state_d = D8_IMEM_ST_READY;
                    cnt_d   = '0;
                end
            end
            D8_IMEM_ST_READY: begin
                if (clr_start) begin
                    state_d = D8_IMEM_ST_CLEAR;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = D8_IMEM_ST_CLEAR;
                cnt_d   = '0;
            end
        endcase

        busy_d      = (state_d == D8_IMEM_ST_CLEAR);
        rdy_d       = (state_d == D8_IMEM_ST_READY);
        fetch_vld_d = fetch_acc;
    end

    // Lane g reads byte fetch_adr+g from its own full-depth copy; a same-cycle write to that byte bypasses.
    for (genvar g = 0; g < IW_BYTES; g++) begin : g_lane
        localparam logic [ADDR_W-1:0] OFF = ADDR_W'(g);

        logic [ADDR_W-1:0] lane_adr;
        logic              lane_hit;

        assign lane_adr = ADDR_W'(fetch_adr + OFF);
        assign lane_hit = wr_acc && (wr_adr == lane_adr);

        d8_imem_bank #(
            .ADDR_W (ADDR_W)
        ) u_bank (
            .clk   (sys_clk),
            .rst_n (sys_rst_n),
            .we    (bank_we),
            .wa    (bank_wa),
            .wd    (bank_wd),
            .re    (fetch_acc),
            .ra    (lane_adr),
            .byp   (lane_hit),
            .rd    (fetch_dout[8*g +: 8])
        );
    end

    assign busy      = busy_q;
    assign fetch_rdy = rdy_q;
    assign wr_rdy    = rdy_q;
    assign fetch_vld = fetch_vld_q;

endmodule

// File: tb/tb_d8_imem.sv
// Directed self-checking bench for d8_imem (ADDR_W=8, IW_BYTES=4, clear on reset).
module tb_d8_imem;

    logic        sys_clk;
    logic        sys_rst_n;
    logic        clr_start;
    logic        busy;
    logic        fetch_req;
    logic [7:0]  fetch_adr;
    logic        fetch_rdy;
    logic        fetch_vld;
    logic [31:0] fetch_dout;
    logic        wr_en;
    logic [7:0]  wr_adr;
    logic [7:0]  wr_dat;
    logic        wr_rdy;

    int n_assert;
    int n_fail;

    d8_imem #(
        .ADDR_W         (8),
        .IW_BYTES       (4),
        .CLEAR_ON_RESET (1'b1)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .clr_start  (clr_start),
        .busy       (busy),
        .fetch_req  (fetch_req),
        .fetch_adr  (fetch_adr),
        .fetch_rdy  (fetch_rdy),
        .fetch_vld  (fetch_vld),
        .fetch_dout (fetch_dout),
        .wr_en      (wr_en),
        .wr_adr     (wr_adr),
        .wr_dat     (wr_dat),
        .wr_rdy     (wr_rdy)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        wr_en  = 1'b1;
        wr_adr = a;
        wr_dat = d;
        step();
        wr_en  = 1'b0;
    endtask

    task automatic fetch_chk(input string tag, input logic [7:0] a, input logic [31:0] exp);
        fetch_req = 1'b1;
        fetch_adr = a;
        step();
        fetch_req = 1'b0;
        chk({tag, "_vld"}, 64'(fetch_vld), 64'd1);
        chk(tag, 64'(fetch_dout), 64'(exp));
    endtask

    // Counts edges until busy drops; observes rdy/vld on every busy cycle.
    task automatic count_busy(output int edges, output int rdy_seen, output int vld_seen);
        edges    = 0;
        rdy_seen = 0;
        vld_seen = 0;
        do begin
            step();
            edges++;
            if (busy && (fetch_rdy || wr_rdy)) rdy_seen++;
            if (fetch_vld) vld_seen++;
        end while (busy && edges < 1000);
    endtask

    initial begin
        int edges;
        int rdy_seen;
        int vld_seen;

        n_assert  = 0;
        n_fail    = 0;
        sys_rst_n = 1'b1;
        clr_start = 1'b0;
        fetch_req = 1'b0;
        fetch_adr = '0;
        wr_en     = 1'b0;
        wr_adr    = '0;
        wr_dat    = '0;

        #2 sys_rst_n = 1'b0;
        #1;
        chk("rst_busy", 64'(busy), 64'd1);
        chk("rst_fetch_rdy", 64'(fetch_rdy), 64'd0);
        chk("rst_wr_rdy", 64'(wr_rdy), 64'd0);
        chk("rst_vld", 64'(fetch_vld), 64'd0);
        chk("rst_dout", 64'(fetch_dout), 64'd0);
        step();
        step();

        // Initial clear with requests held active: they must be ignored.
        sys_rst_n = 1'b1;
        fetch_req = 1'b1;
        fetch_adr = 8'h00;
        wr_en     = 1'b1;
        wr_adr    = 8'h00;
        wr_dat    = 8'h11;
        count_busy(edges, rdy_seen, vld_seen);
        fetch_req = 1'b0;
        wr_en     = 1'b0;
        chk("clr_cycles", 64'(edges), 64'd256);
        chk("clr_rdy_seen", 64'(rdy_seen), 64'd0);
        chk("clr_vld_seen", 64'(vld_seen), 64'd0);
        chk("ready_fetch_rdy", 64'(fetch_rdy), 64'd1);
        chk("ready_wr_rdy", 64'(wr_rdy), 64'd1);

        fetch_chk("f00_zero", 8'h00, 32'h0000_0000);

        wr(8'h04, 8'h30);
        wr(8'h05, 8'h00);
        wr(8'h06, 8'h01);
        wr(8'h07, 8'h10);
        fetch_chk("f04", 8'h04, 32'h1001_0030);
        step();
        chk("f04_pulse_end", 64'(fetch_vld), 64'd0);
        chk("f04_hold", 64'(fetch_dout), 64'h1001_0030);

        wr(8'hFF, 8'hAA);
        wr(8'h00, 8'hBB);
        wr(8'h01, 8'hCC);
        wr(8'h02, 8'hDD);
        fetch_chk("fFF_wrap", 8'hFF, 32'hDDCC_BBAA);

        // Same-cycle write into the fetch window.
        wr_en  = 1'b1;
        wr_adr = 8'h12;
        wr_dat = 8'h55;
        fetch_chk("byp_f10", 8'h10, 32'h0055_0000);
        wr_en  = 1'b0;
        fetch_chk("f10_after", 8'h10, 32'h0055_0000);

        wr_en  = 1'b1;
        wr_adr = 8'h01;
        wr_dat = 8'hEE;
        fetch_chk("byp_wrap", 8'hFF, 32'hDDEE_BBAA);
        wr_en  = 1'b0;

        // Back-to-back fetches.
        fetch_req = 1'b1;
        fetch_adr = 8'h00;
        step();
        chk("b2b0_vld", 64'(fetch_vld), 64'd1);
        chk("b2b0", 64'(fetch_dout), 64'h00DD_EEBB);
        fetch_adr = 8'h04;
        step();
        chk("b2b1_vld", 64'(fetch_vld), 64'd1);
        chk("b2b1", 64'(fetch_dout), 64'h1001_0030);
        fetch_adr = 8'h08;
        step();
        chk("b2b2_vld", 64'(fetch_vld), 64'd1);
        chk("b2b2", 64'(fetch_dout), 64'h0000_0000);
        fetch_req = 1'b0;
        step();
        chk("b2b_end", 64'(fetch_vld), 64'd0);

        // clr_start with a same-cycle write; a second pulse during CLEAR must not restart it.
        clr_start = 1'b1;
        wr_en     = 1'b1;
        wr_adr    = 8'h20;
        wr_dat    = 8'h77;
        step();
        clr_start = 1'b0;
        wr_en     = 1'b0;
        chk("clr_req_busy", 64'(busy), 64'd1);
        chk("clr_req_rdy", 64'(fetch_rdy), 64'd0);
        step();
        clr_start = 1'b1;
        step();
        clr_start = 1'b0;
        count_busy(edges, rdy_seen, vld_seen);
        chk("clr_req_cycles", 64'(edges + 2), 64'd256);
        chk("clr_req_rdy_seen", 64'(rdy_seen), 64'd0);
        fetch_chk("cleared_f04", 8'h04, 32'h0000_0000);
        fetch_chk("cleared_f20", 8'h20, 32'h0000_0000);
        fetch_chk("cleared_fFF", 8'hFF, 32'h0000_0000);

        // Reset in the middle of a fetch result.
        wr(8'h04, 8'h99);
        fetch_req = 1'b1;
        fetch_adr = 8'h04;
        step();
        chk("pre_rst_vld", 64'(fetch_vld), 64'd1);
        chk("pre_rst_dout", 64'(fetch_dout), 64'h0000_0099);
        fetch_req = 1'b0;
        sys_rst_n = 1'b0;
        #1;
        chk("async_vld", 64'(fetch_vld), 64'd0);
        chk("async_dout", 64'(fetch_dout), 64'd0);
        chk("async_busy", 64'(busy), 64'd1);
        step();
        sys_rst_n = 1'b1;

        // Reset again at clear cycle 100: sweep restarts from zero.
        for (int i = 0; i < 100; i++) step();
        chk("mid_clr_busy", 64'(busy), 64'd1);
        sys_rst_n = 1'b0;
        step();
        sys_rst_n = 1'b1;
        count_busy(edges, rdy_seen, vld_seen);
        chk("restart_cycles", 64'(edges), 64'd256);
        fetch_chk("restart_f04", 8'h04, 32'h0000_0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
